packet_split: RTL and testbench

PACKET_SPLIT -- requirements
Module: packet_split

---
 rtl/packet_split_pkg.sv | 25 ++
 rtl/split_out_reg.sv | 51 +++++
 rtl/packet_split.sv | 159 +++++++++++++++
 tb/tb_packet_split.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_split_pkg.sv
// Shared types and defaults for the packet splitter: framing-state encoding,
// default word widths and the statistics counter width.
package packet_split_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int CTRL_W_DEF = 8;
  localparam int CNT_W      = 16;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HDR  = 2'b01,
    ST_BODY = 2'b10,
    ST_BAD  = 2'b11
  } state_e;

  // Preferred port wins if it has room, otherwise the other one.
  function automatic logic pick_port(input logic pref, input logic rdy0, input logic rdy1);
    logic pref_rdy;
    pref_rdy = pref ? rdy1 : rdy0;
    return pref_rdy ? pref : ~pref;
  endfunction

endpackage

// File: rtl/split_out_reg.sv
// One output port's registered stage: strobe follows wr_en each cycle,
// ctrl/data capture only on a write and otherwise hold.
module split_out_reg
  import packet_split_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int CTRL_WIDTH = CTRL_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [CTRL_WIDTH-1:0] ctrl_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  out_wr,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic                  wr_d,   wr_q;
  logic [CTRL_WIDTH-1:0] ctrl_d, ctrl_q;
  logic [DATA_WIDTH-1:0] data_d, data_q;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
    wr_d   = wr_en;
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (wr_en) begin
      ctrl_d = ctrl_in;
      data_d = data_in;
    end
  end

  // NOTE: state registers use non-blocking assignment and are all cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q   <= 1'b0;
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      wr_q   <= wr_d;
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  assign out_wr   = wr_q;
  assign out_ctrl = ctrl_q;
  assign out_data = data_q;

endmodule

// File: rtl/packet_split.sv
// Steers framed packets from one upstream stream to one of two output ports,
// alternating preference per packet and counting packets and dropped words.
module packet_split
  import packet_split_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int CTRL_WIDTH = CTRL_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_wr,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_rdy,
  output logic                  out_wr0,
  output logic [CTRL_WIDTH-1:0] out_ctrl0,
  output logic [DATA_WIDTH-1:0] out_data0,
  output logic                  out_wr1,
  output logic [CTRL_WIDTH-1:0] out_ctrl1,
  output logic [DATA_WIDTH-1:0] out_data1,
  input  logic                  out_rdy0,
  input  logic                  out_rdy1,
  output logic                  sel,
  output logic [1:0]            state,
  output logic [CNT_W-1:0]      pkt_cnt0,
  output logic [CNT_W-1:0]      pkt_cnt1,
  output logic [CNT_W-1:0]      drop_cnt
);

  state_e           state_d, state_q;
  logic             sel_d,   sel_q;
  logic             pref_d,  pref_q;
  logic [CNT_W-1:0] pkt0_d,  pkt0_q;
  logic [CNT_W-1:0] pkt1_d,  pkt1_q;
  logic [CNT_W-1:0] drop_d,  drop_q;

  logic rdy;
  logic accept;
  logic is_ctrl;
  logic dest;
  logic fwd0, fwd1;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pref_d  = pref_q;
    pkt0_d  = pkt0_q;
    pkt1_d  = pkt1_q;
    drop_d  = drop_q;
    fwd0    = 1'b0;
    fwd1    = 1'b0;
    dest    = sel_q;
    is_ctrl = (in_ctrl != '0);

    // Mid-packet only the locked port's room matters.
    unique case (state_q)
      ST_IDLE:         rdy = out_rdy0 | out_rdy1;
      ST_HDR, ST_BODY: rdy = sel_q ? out_rdy1 : out_rdy0;
      default:         rdy = 1'b0;
    endcase
    accept = in_wr & rdy;

    if (in_wr && !rdy) begin
      drop_d = drop_q + CNT_ONE;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_ctrl) begin
            dest    = pick_port(pref_q, out_rdy0, out_rdy1);
            sel_d   = dest;
            state_d = ST_HDR;
            fwd0    = ~dest;
            fwd1    = dest;
          end else begin
            drop_d = drop_q + CNT_ONE;
          end
        end
      end
      ST_HDR: begin
        if (accept) begin
          fwd0 = ~sel_q;
          fwd1 = sel_q;
          if (!is_ctrl) begin
            state_d = ST_BODY;
          end
        end
      end
      ST_BODY: begin
        if (accept) begin
          fwd0 = ~sel_q;
          fwd1 = sel_q;
          if (is_ctrl) begin
            state_d = ST_IDLE;
            pref_d  = ~pref_q;
            if (sel_q) pkt1_d = pkt1_q + CNT_ONE;
            else       pkt0_d = pkt0_q + CNT_ONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= 1'b0;
      pref_q  <= 1'b0;
      pkt0_q  <= '0;
      pkt1_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      pref_q  <= pref_d;
      pkt0_q  <= pkt0_d;
      pkt1_q  <= pkt1_d;
      drop_q  <= drop_d;
    end
  end

  split_out_reg #(
    .DATA_WIDTH(DATA_WIDTH),
    .CTRL_WIDTH(CTRL_WIDTH)
  ) u_out0 (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (fwd0),
    .ctrl_in (in_ctrl),
    .data_in (in_data),
    .out_wr  (out_wr0),
    .out_ctrl(out_ctrl0),
    .out_data(out_data0)
  );

  split_out_reg #(
    .DATA_WIDTH(DATA_WIDTH),
    .CTRL_WIDTH(CTRL_WIDTH)
  ) u_out1 (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (fwd1),
    .ctrl_in (in_ctrl),
    .data_in (in_data),
    .out_wr  (out_wr1),
    .out_ctrl(out_ctrl1),
    .out_data(out_data1)
  );

  assign in_rdy   = rdy;
  assign sel      = sel_q;
  assign state    = state_q;
  assign pkt_cnt0 = pkt0_q;
  assign pkt_cnt1 = pkt1_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_packet_split.sv
// Scoreboard bench for packet_split: directed packets push expected words per
// port; a monitor pops and compares them, including the one-cycle latency.
module tb_packet_split;

  localparam int DW = 64;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_wr;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          in_rdy;
  logic          out_wr0, out_wr1;
  logic [CW-1:0] out_ctrl0, out_ctrl1;
  logic [DW-1:0] out_data0, out_data1;
  logic          out_rdy0, out_rdy1;
  logic          sel;
  logic [1:0]    state;
  logic [15:0]   pkt_cnt0, pkt_cnt1, drop_cnt;

  packet_split #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_wr    (in_wr),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .in_rdy   (in_rdy),
    .out_wr0  (out_wr0),
    .out_ctrl0(out_ctrl0),
    .out_data0(out_data0),
    .out_wr1  (out_wr1),
    .out_ctrl1(out_ctrl1),
    .out_data1(out_data1),
    .out_rdy0 (out_rdy0),
    .out_rdy1 (out_rdy1),
    .sel      (sel),
    .state    (state),
    .pkt_cnt0 (pkt_cnt0),
    .pkt_cnt1 (pkt_cnt1),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sample one time unit after the edge that registers the output.
  always @(posedge clk) begin
    #1;
    if (out_wr0 === 1'b1 && out_wr1 === 1'b1) check("both_wr", 1, 0);
    if (out_wr0 === 1'b1) begin
      if (q0.size() == 0) check("p0_unexpected", 1, 0);
      else begin
        exp_t e;
        e = q0.pop_front();
        check("p0_ctrl", out_ctrl0, e.ctrl);
        check("p0_data", out_data0, e.data);
        check("p0_cycle", cyc, e.cyc);
      end
    end
    if (out_wr1 === 1'b1) begin
      if (q1.size() == 0) check("p1_unexpected", 1, 0);
      else begin
        exp_t e;
        e = q1.pop_front();
        check("p1_ctrl", out_ctrl1, e.ctrl);
        check("p1_data", out_data1, e.data);
        check("p1_cycle", cyc, e.cyc);
      end
    end
  end

  // Drive one word for one cycle; port -1 means the word must not come out.
  task automatic send(input logic [CW-1:0] c, input logic [DW-1:0] d, input int port);
    exp_t e;
    in_wr   = 1'b1;
    in_ctrl = c;
    in_data = d;
    e.ctrl  = c;
    e.data  = d;
    e.cyc   = cyc + 1;
    if (port == 0) q0.push_back(e);
    else if (port == 1) q1.push_back(e);
    @(negedge clk);
    in_wr = 1'b0;
  endtask

  task automatic idle(input int n);
    in_wr = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic set_rdy(input logic r0, input logic r1);
    out_rdy0 = r0;
    out_rdy1 = r1;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; in_wr = 1'b0; in_ctrl = '0; in_data = '0;
    out_rdy0 = 1'b1; out_rdy1 = 1'b1;
    repeat (2) @(negedge clk);

    // Reset values and combinational in_rdy while still in reset.
    check("rst_state", state, 2'b00);
    check("rst_sel", sel, 0);
    check("rst_wr0", out_wr0, 0);
    check("rst_wr1", out_wr1, 0);
    check("rst_ctrl0", out_ctrl0, 0);
    check("rst_data1", out_data1, 0);
    check("rst_pkt0", pkt_cnt0, 0);
    check("rst_pkt1", pkt_cnt1, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_rdy_11", in_rdy, 1);
    set_rdy(0, 0); check("rst_rdy_00", in_rdy, 0);
    set_rdy(0, 1); check("rst_rdy_01", in_rdy, 1);
    set_rdy(1, 1);
    @(negedge clk);
    reset = 1'b0;

    // Two 4-word packets with both ports ready: alternate 0 then 1.
    send(8'hFF, 64'hA000_0000_0000_0001, 0);
    check("t1_state_hdr", state, 2'b01);
    check("t1_sel0", sel, 0);
    send(8'h00, 64'hA000_0000_0000_0002, 0);
    check("t1_state_body", state, 2'b10);
    send(8'h00, 64'hA000_0000_0000_0003, 0);
    send(8'h04, 64'hA000_0000_0000_0004, 0);
    check("t1_state_idle", state, 2'b00);
    send(8'hFF, 64'hB000_0000_0000_0001, 1);
    check("t1_sel1", sel, 1);
    send(8'h00, 64'hB000_0000_0000_0002, 1);
    send(8'h00, 64'hB000_0000_0000_0003, 1);
    send(8'h04, 64'hB000_0000_0000_0004, 1);
    idle(2);
    check("t1_pkt0", pkt_cnt0, 1);
    check("t1_pkt1", pkt_cnt1, 1);
    check("t1_drop", drop_cnt, 0);
    check("t1_hold_wr0", out_wr0, 0);
    check("t1_hold_data0", out_data0, 64'hA000_0000_0000_0004);
    check("t1_hold_ctrl0", out_ctrl0, 8'h04);

    // Preferred port 0 not ready: packet goes to port 1, in_rdy follows out_rdy1.
    set_rdy(0, 1);
    check("t2_rdy_idle", in_rdy, 1);
    send(8'hFF, 64'hC000_0000_0000_0001, 1);
    check("t2_sel", sel, 1);
    send(8'h00, 64'hC000_0000_0000_0002, 1);
    set_rdy(1, 0); check("t2_rdy_track0", in_rdy, 0);
    set_rdy(0, 1); check("t2_rdy_track1", in_rdy, 1);
    send(8'h00, 64'hC000_0000_0000_0003, 1);
    send(8'h04, 64'hC000_0000_0000_0004, 1);
    idle(2);
    check("t2_pkt1", pkt_cnt1, 2);
    check("t2_pkt0", pkt_cnt0, 1);

    // Preference is now port 1; stall it mid-body for three upstream words.
    set_rdy(1, 1);
    send(8'hFF, 64'hD000_0000_0000_0001, 1);
    send(8'h00, 64'hD000_0000_0000_0002, 1);
    set_rdy(1, 0);
    check("t3_rdy_low", in_rdy, 0);
    for (int i = 0; i < 3; i++) begin
      send(8'h00, 64'hD000_0000_0000_0010 + DW'(i), -1);
      check("t3_wr1_low", out_wr1, 0);
      check("t3_wr0_low", out_wr0, 0);
    end
    check("t3_sel", sel, 1);
    check("t3_state", state, 2'b10);
    check("t3_drop", drop_cnt, 3);
    set_rdy(1, 1);
    send(8'h00, 64'hD000_0000_0000_0006, 1);
    send(8'h04, 64'hD000_0000_0000_0007, 1);
    idle(2);
    check("t3_pkt1", pkt_cnt1, 3);
    check("t3_drop_after", drop_cnt, 3);

    // Body-type word while idle is dropped.
    send(8'h00, 64'hE000_0000_0000_0001, -1);
    idle(1);
    check("t4_drop", drop_cnt, 4);
    check("t4_state", state, 2'b00);
    check("t4_wr0", out_wr0, 0);
    check("t4_wr1", out_wr1, 0);

    // Reset in BODY: rest of body dropped, end word opens a new header.
    send(8'hFF, 64'hF000_0000_0000_0001, 0);
    send(8'h00, 64'hF000_0000_0000_0002, 0);
    check("t5_state_body", state, 2'b10);
    reset = 1'b1;
    #1;
    check("t5_rst_state", state, 2'b00);
    check("t5_rst_wr0", out_wr0, 0);
    @(negedge clk);
    reset = 1'b0;
    check("t5_rst_pkt0", pkt_cnt0, 0);
    check("t5_rst_drop", drop_cnt, 0);
    check("t5_rst_data0", out_data0, 0);
    send(8'h00, 64'hF000_0000_0000_0003, -1);
    send(8'h00, 64'hF000_0000_0000_0004, -1);
    check("t5_drop", drop_cnt, 2);
    send(8'h04, 64'hF000_0000_0000_0005, 0);
    check("t5_new_hdr", state, 2'b01);
    check("t5_sel", sel, 0);
    send(8'h00, 64'hF000_0000_0000_0006, 0);
    send(8'h04, 64'hF000_0000_0000_0007, 0);
    idle(2);
    check("t5_pkt0", pkt_cnt0, 1);
    check("t5_state_end", state, 2'b00);

    // 16-bit counter wrap: drive drops until drop_cnt passes FFFF.
    set_rdy(0, 0);
    in_wr = 1'b1; in_ctrl = 8'hFF; in_data = 64'h0;
    repeat (65533) @(negedge clk);
    check("t6_drop_ffff", drop_cnt, 16'hFFFF);
    @(negedge clk);
    in_wr = 1'b0;
    check("t6_drop_wrap", drop_cnt, 16'h0000);
    check("t6_state", state, 2'b00);
    check("t6_pkt0", pkt_cnt0, 1);
    idle(2);

    check("q0_empty", q0.size(), 0);
    check("q1_empty", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
